// File: rtl/rt_pkg.sv
// Shared sizing constants and conversion-FSM state encoding for the reaction timer.
package rt_pkg;

  localparam int CNT_W  = 14;
  localparam int MAX_MS = 9999;
  localparam int DIGITS = 4;

  typedef enum logic [1:0] {
    C_IDLE,
    C_LOAD,
    C_SHIFT,
    C_DONE
  } conv_state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift per cycle. Requests that arrive mid-conversion
// are folded into a single re-run so that only the newest source value is published.
module bin2bcd_seq
  import rt_pkg::*;
#(
  parameter int W = CNT_W,
  parameter int D = DIGITS
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   bin,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd
);

  localparam int SC_W = $clog2(W);

  conv_state_t     state;
  logic            pending;
  logic [W-1:0]    src;
  logic [4*D-1:0]  acc;
  logic [4*D-1:0]  acc_adj;
  logic [SC_W-1:0] shift_cnt;

  for (genvar gi = 0; gi < D; gi++) begin : g_adj
    assign acc_adj[4*gi +: 4] = (acc[4*gi +: 4] >= 4'd5) ? acc[4*gi +: 4] + 4'd3
                                                         : acc[4*gi +: 4];
  end

  assign busy = (state != C_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= C_IDLE;
      pending   <= 1'b0;
      src       <= '0;
      acc       <= '0;
      shift_cnt <= '0;
      done      <= 1'b0;
      bcd       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        C_IDLE: begin
          if (start) state <= C_LOAD;
        end
        C_LOAD: begin
          src       <= bin;
          acc       <= '0;
          shift_cnt <= '0;
          if (start) pending <= 1'b1;
          state     <= C_SHIFT;
        end
        C_SHIFT: begin
          if (start) pending <= 1'b1;
          acc       <= {acc_adj[4*D-2:0], src[W-1]};
          src       <= {src[W-2:0], 1'b0};
          shift_cnt <= shift_cnt + 1'b1;
          if (shift_cnt == SC_W'(W - 1)) state <= C_DONE;
        end
        C_DONE: begin
          // A superseded result is dropped; only the rerun gets published.
          if (pending || start) begin
            pending <= 1'b0;
            state   <= C_LOAD;
          end else begin
            bcd   <= acc;
            done  <= 1'b1;
            state <= C_IDLE;
          end
        end
        default: state <= C_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time counter with capture, best-score tracking and BCD display output.
module reaction_timer #(
  parameter int CNT_W  = rt_pkg::CNT_W,
  parameter int MAX_MS = rt_pkg::MAX_MS,
  parameter int DIGITS = rt_pkg::DIGITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ms_tick,
  input  logic                timer_en,
  input  logic                show_time,
  input  logic                early_error,
  input  logic                show_best,
  input  logic                clear_best,
  output logic [CNT_W-1:0]    last_ms,
  output logic [CNT_W-1:0]    best_ms,
  output logic                best_valid,
  output logic                new_best,
  output logic                overflow,
  output logic [4*DIGITS-1:0] bcd,
  output logic                bcd_valid
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_MS);

  logic timer_en_reg, show_time_reg, early_error_reg, show_best_reg;
  logic [CNT_W-1:0] count_reg, last_ms_reg, best_ms_reg;
  logic best_valid_reg, new_best_reg, overflow_reg, bcd_valid_reg;
  logic timer_rise, show_rise, early_rise, conv_req, take_best;
  logic [CNT_W-1:0] conv_src;
  logic conv_busy, conv_done;

  assign timer_rise = timer_en & ~timer_en_reg;
  assign show_rise  = show_time & ~show_time_reg;
  assign early_rise = early_error & ~early_error_reg;
  assign conv_req   = show_rise | (show_best ^ show_best_reg) | (clear_best & show_best);
  // A coincident clear counts as "no best yet", so the capture wins the slot.
  assign take_best  = show_rise & ~overflow_reg &
                      (clear_best | ~best_valid_reg | (count_reg < best_ms_reg));
  assign conv_src   = show_best ? best_ms_reg : last_ms_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_en_reg    <= 1'b0;
      show_time_reg   <= 1'b0;
      early_error_reg <= 1'b0;
      show_best_reg   <= 1'b0;
      count_reg       <= '0;
      last_ms_reg     <= '0;
      best_ms_reg     <= MAX_CNT;
      best_valid_reg  <= 1'b0;
      new_best_reg    <= 1'b0;
      overflow_reg    <= 1'b0;
      bcd_valid_reg   <= 1'b0;
    end else begin
      timer_en_reg    <= timer_en;
      show_time_reg   <= show_time;
      early_error_reg <= early_error;
      show_best_reg   <= show_best;
      new_best_reg    <= take_best;

      if (timer_rise) begin
        count_reg    <= ms_tick ? CNT_W'(1) : '0;
        overflow_reg <= 1'b0;
      end else if (timer_en) begin
        if (count_reg == MAX_CNT) overflow_reg <= 1'b1;
        else if (ms_tick) count_reg <= count_reg + 1'b1;
      end

      if (show_rise) last_ms_reg <= count_reg;

      if (take_best) begin
        best_ms_reg    <= count_reg;
        best_valid_reg <= 1'b1;
      end else if (clear_best) begin
        best_ms_reg    <= MAX_CNT;
        best_valid_reg <= 1'b0;
      end

      if (conv_req || timer_rise || early_rise) bcd_valid_reg <= 1'b0;
      else if (conv_done && !conv_busy) bcd_valid_reg <= 1'b1;
    end
  end

  bin2bcd_seq #(
    .W (CNT_W),
    .D (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_req),
    .bin   (conv_src),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  assign last_ms    = last_ms_reg;
  assign best_ms    = best_ms_reg;
  assign best_valid = best_valid_reg;
  assign new_best   = new_best_reg;
  assign overflow   = overflow_reg;
  assign bcd_valid  = bcd_valid_reg;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer: captures, best tracking, saturation and BCD display.
module tb_reaction_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ms_tick = 1'b0;
  logic        timer_en = 1'b0;
  logic        show_time = 1'b0;
  logic        early_error = 1'b0;
  logic        show_best = 1'b0;
  logic        clear_best = 1'b0;
  logic [13:0] last_ms, best_ms;
  logic        best_valid, new_best, overflow, bcd_valid;
  logic [15:0] bcd;

  int n_checks = 0;
  int n_fail   = 0;
  int first_valid;

  reaction_timer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ms_tick     (ms_tick),
    .timer_en    (timer_en),
    .show_time   (show_time),
    .early_error (early_error),
    .show_best   (show_best),
    .clear_best  (clear_best),
    .last_ms     (last_ms),
    .best_ms     (best_ms),
    .best_valid  (best_valid),
    .new_best    (new_best),
    .overflow    (overflow),
    .bcd         (bcd),
    .bcd_valid   (bcd_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, act);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Runs one attempt of n ticks; returns just after the capture edge.
  task automatic attempt(input int n, input logic clr);
    show_time = 1'b0;
    cyc(1);
    timer_en = 1'b1;
    ms_tick  = 1'b1;
    cyc(n);
    timer_en = 1'b0;
    ms_tick  = 1'b0;
    cyc(1);
    show_time  = 1'b1;
    clear_best = clr;
    cyc(1);
    clear_best = 1'b0;
  endtask

  // Called just after the request edge: result appears 17 edges after it.
  task automatic expect_bcd(input string tag, input logic [15:0] exp);
    cyc(16);
    check({tag, " valid@16"}, bcd_valid, 1'b0);
    cyc(1);
    check({tag, " valid@17"}, bcd_valid, 1'b1);
    check({tag, " bcd"}, bcd, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    check("rst last_ms", last_ms, 0);
    check("rst best_ms", best_ms, 9999);
    check("rst best_valid", best_valid, 0);
    check("rst new_best", new_best, 0);
    check("rst overflow", overflow, 0);
    check("rst bcd", bcd, 0);
    check("rst bcd_valid", bcd_valid, 0);
    rst_n = 1'b1;
    cyc(2);

    // 1: first attempt becomes best
    attempt(237, 1'b0);
    check("t1 last_ms", last_ms, 237);
    check("t1 new_best", new_best, 1);
    check("t1 best_ms", best_ms, 237);
    check("t1 best_valid", best_valid, 1);
    check("t1 overflow", overflow, 0);
    expect_bcd("t1", 16'h0237);
    check("t1 new_best gone", new_best, 0);

    // 2: slower attempt, then view best
    attempt(300, 1'b0);
    check("t2 last_ms", last_ms, 300);
    check("t2 new_best", new_best, 0);
    check("t2 best_ms", best_ms, 237);
    expect_bcd("t2 last", 16'h0300);
    show_best = 1'b1;
    cyc(1);
    check("t2 toggle drops valid", bcd_valid, 0);
    expect_bcd("t2 best", 16'h0237);

    // 3: saturation
    show_best = 1'b0;
    cyc(1);
    expect_bcd("t3 back to last", 16'h0300);
    attempt(12000, 1'b0);
    check("t3 last_ms", last_ms, 9999);
    check("t3 overflow", overflow, 1);
    check("t3 best_ms", best_ms, 237);
    check("t3 new_best", new_best, 0);
    expect_bcd("t3", 16'h9999);

    // 4: early error invalidates display only
    early_error = 1'b1;
    cyc(1);
    early_error = 1'b0;
    check("t4 bcd_valid", bcd_valid, 0);
    check("t4 last_ms", last_ms, 9999);
    check("t4 best_ms", best_ms, 237);
    cyc(20);
    check("t4 no conversion", bcd_valid, 0);

    // 5: two extra toggles mid-conversion -> one result, after the rerun
    show_best = 1'b1;
    cyc(1);
    cyc(3);
    show_best = 1'b0;
    cyc(1);
    cyc(1);
    show_best = 1'b1;
    cyc(1);
    first_valid = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      if (bcd_valid && first_valid == 0) first_valid = i;
    end
    check("t5 first valid cycle", first_valid, 27);
    check("t5 bcd", bcd, 16'h0237);

    // 6: clear alone, then clear coinciding with a capture
    clear_best = 1'b1;
    cyc(1);
    clear_best = 1'b0;
    check("t6 clr best_ms", best_ms, 9999);
    check("t6 clr best_valid", best_valid, 0);
    expect_bcd("t6 clr", 16'h9999);
    attempt(300, 1'b1);
    check("t6 cap last_ms", last_ms, 300);
    check("t6 cap best_ms", best_ms, 300);
    check("t6 cap best_valid", best_valid, 1);
    check("t6 cap new_best", new_best, 1);
    check("t6 cap overflow", overflow, 0);

    // reset in the middle of SHIFT
    cyc(5);
    show_best = 1'b0;
    show_time = 1'b0;
    rst_n = 1'b0;
    cyc(1);
    check("t6 rst last_ms", last_ms, 0);
    check("t6 rst best_ms", best_ms, 9999);
    check("t6 rst best_valid", best_valid, 0);
    check("t6 rst new_best", new_best, 0);
    check("t6 rst overflow", overflow, 0);
    check("t6 rst bcd", bcd, 0);
    check("t6 rst bcd_valid", bcd_valid, 0);
    rst_n = 1'b1;
    cyc(20);
    check("t6 aborted valid", bcd_valid, 0);
    check("t6 aborted bcd", bcd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
